// File: rtl/chess_pkg.sv
// Shared chess-board package: button event codes and button indices used by
// the input front-end and the board logic.
package chess_pkg;

  typedef enum logic [2:0] {
    EVT_NONE   = 3'd0,
    EVT_UP     = 3'd1,
    EVT_DOWN   = 3'd2,
    EVT_LEFT   = 3'd3,
    EVT_RIGHT  = 3'd4,
    EVT_CENTER = 3'd5
  } evt_code_e;

  localparam int unsigned EVT_W      = 3;
  localparam int unsigned NUM_BTN    = 5;
  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

  // Button index order matches event code order, offset by one.
  function automatic logic [EVT_W-1:0] btn_code(input logic [EVT_W-1:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Per-button front end: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle rise pulse for each debounced press.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1;
  logic          s2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_q <= level;
      rise    <= level & ~level_q;
      // Counter only runs while the synchronized input disagrees with the level.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_source.sv
// Five-button event source: debounce, pending flags, priority arbiter and an
// event FIFO. Define BUTTON_AUTO_REPEAT_EN to add direction auto-repeat.
module button_event_source
  import chess_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 3750000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BTNU,
  input  logic             BTND,
  input  logic             BTNL,
  input  logic             BTNR,
  input  logic             BTNC,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_code,
  input  logic             evt_ready,
  output logic             evt_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] rep;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] clr;
  logic               sel_vld;
  logic [EVT_W-1:0]   sel_idx;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop;
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [EVT_W-1:0]   mem [FIFO_DEPTH];

  assign raw = {BTNC, BTNR, BTNL, BTND, BTNU};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (raw[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = $clog2(RMAX + 1);

  logic [TW-1:0] rep_tmr [4];
  logic [3:0]    rep_first;

  // Repeat fires on the delay after the press, then on every period while held.
  always_comb begin
    rep = '0;
    for (int i = 0; i < 4; i++) begin
      rep[i] = level[i] && (rep_first[i] ? (rep_tmr[i] == TW'(REPEAT_DELAY - 1))
                                         : (rep_tmr[i] == TW'(REPEAT_PERIOD - 1)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rep_tmr[i] <= '0;
      rep_first <= '1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rise[i] || !level[i]) begin
          rep_tmr[i]   <= '0;
          rep_first[i] <= 1'b1;
        end else if (rep[i]) begin
          rep_tmr[i]   <= '0;
          rep_first[i] <= 1'b0;
        end else begin
          rep_tmr[i] <= rep_tmr[i] + TW'(1);
        end
      end
    end
  end
`else
  logic unused_level;
  assign unused_level = ^level;
  assign rep = '0;
`endif

  // Fixed priority: CENTER, then UP, DOWN, LEFT, RIGHT.
  always_comb begin
    sel_vld = |pending;
    sel_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) sel_idx = 3'(i);
    end
    if (pending[BTN_CENTER]) sel_idx = 3'(BTN_CENTER);
    clr = sel_vld ? (NUM_BTN'(1) << sel_idx) : '0;
  end

  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign evt_valid = (wptr != rptr);
  assign pop       = evt_valid && evt_ready;
  assign push      = sel_vld && (!full || pop);
  assign drop      = sel_vld && full && !pop;
  assign evt_code  = evt_valid ? mem[rptr[AW-1:0]] : EVT_NONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending      <= '0;
      wptr         <= '0;
      rptr         <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | rise | rep;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (drop) evt_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= btn_code(sel_idx);
  end

endmodule

// File: tb/tb_button_event_source.sv
// Randomized scoreboard bench for button_event_source with a behavioural model
// of debounce windows, press flags, arbitration and queue occupancy.
module tb_button_event_source;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;
  localparam int unsigned FD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_event_source #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .BTNU(btn[0]), .BTND(btn[1]), .BTNL(btn[2]), .BTNR(btn[3]), .BTNC(btn[4]),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_overflow(evt_overflow)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [31:0] hist [5];
  logic [4:0]  mlvl, tog1, tog2, mpend, m_set, m_tog;
  int          mcount, mcyc, m_pick, pstart [5];
  bit          movf, m_pop, m_all, pval [5];
  int          sb [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 5; b++) begin hist[b] = '0; pval[b] = 0; pstart[b] = 0; end
      mlvl = '0; tog1 = '0; tog2 = '0; mpend = '0;
      mcount = 0; mcyc = 0; movf = 0;
      sb.delete();
    end else begin
      mcyc++;
      m_pop  = (mcount > 0) && evt_ready;
      m_pick = -1;
      if (mpend[4]) m_pick = 4;
      else for (int b = 0; b < 4; b++) if (m_pick < 0 && mpend[b]) m_pick = b;
      m_set = tog2;
`ifdef BUTTON_AUTO_REPEAT_EN
      for (int b = 0; b < 4; b++) begin
        if (mlvl[b] && pval[b]) begin
          int d;
          d = mcyc - pstart[b];
          if (d == int'(RD) || (d > int'(RD) && (d - int'(RD)) % int'(RP) == 0)) m_set[b] = 1'b1;
        end
      end
`endif
      if (m_pick >= 0) begin
        mpend[m_pick] = 1'b0;
        if (mcount < int'(FD) || m_pop) begin
          sb.push_back(m_pick + 1);
          mcount++;
        end else begin
          movf = 1;
        end
      end
      if (m_pop) mcount--;
      mpend = mpend | m_set;
      for (int b = 0; b < 5; b++) if (tog2[b]) begin pstart[b] = mcyc; pval[b] = 1; end
      // Level flips once the last DB synchronized samples all disagree with it.
      m_tog = '0;
      for (int b = 0; b < 5; b++) begin
        m_all = 1;
        for (int k = 1; k <= int'(DB); k++) if (hist[b][k] == mlvl[b]) m_all = 0;
        if (m_all) begin
          if (!mlvl[b]) m_tog[b] = 1'b1;
          else pval[b] = 0;
          mlvl[b] = ~mlvl[b];
        end
        hist[b] = {hist[b][30:0], btn[b]};
      end
      tog2 = tog1;
      tog1 = m_tog;
    end
  end

  // Monitor: compare DUT outputs against the scoreboard head every cycle.
  always @(negedge clk) begin
    chk("valid", int'(evt_valid), (sb.size() > 0) ? 1 : 0);
    if (sb.size() > 0) chk("code", int'(evt_code), sb[0]);
    else chk("code_idle", int'(evt_code), 0);
    chk("overflow", int'(evt_overflow), int'(movf));
    if (sb.size() > 0 && evt_ready && !reset) void'(sb.pop_front());
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic measure(input int t0, output int first_dt, output int first_code, output int nval);
    first_dt = -1; first_code = -1; nval = 0;
    repeat (30) begin
      @(negedge clk);
      if (evt_valid) begin
        if (first_dt < 0) begin first_dt = cyc - t0; first_code = int'(evt_code); end
        nval++;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1; step(1); reset = 1'b0; step(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, dt, code, nv;
    int hold [5];
    step(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_ovf", int'(evt_overflow), 0);
    reset = 1'b0;
    step(5);

    // Single press latency and one-shot behaviour
    evt_ready = 1'b1;
    t0 = cyc;
    btn[0] = 1'b1;
    measure(t0, dt, code, nv);
    chk("up_latency", dt, 9);
    chk("up_code", code, 1);
    chk("up_once", nv, 1);
    btn[0] = 1'b0;
    step(20);

    // Short glitches never reach the debounced level
    for (int i = 0; i < 5; i++) begin btn[2] = 1'b1; step(3); btn[2] = 1'b0; step(3); end
    step(10);
    chk("glitch_idle", int'(evt_valid), 0);

    // Simultaneous CENTER and RIGHT: CENTER first
    evt_ready = 1'b0;
    btn[4] = 1'b1; btn[3] = 1'b1;
    step(14);
    chk("cr_valid", int'(evt_valid), 1);
    chk("cr_head", int'(evt_code), 5);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    chk("cr_second", int'(evt_code), 4);
    btn = '0; evt_ready = 1'b1;
    step(20);
    chk("cr_drained", int'(evt_valid), 0);

    // Six presses into a four-deep queue
    pulse_reset();
    evt_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin btn[b] = 1'b1; step(10); end
    btn[0] = 1'b0; step(10); btn[0] = 1'b1; step(12);
    chk("six_ovf", int'(evt_overflow), 1);
    chk("six_valid", int'(evt_valid), 1);
    chk("six_head", int'(evt_code), 1);

    // Reset with three events queued and every button held
    evt_ready = 1'b1; step(1); evt_ready = 1'b0; step(1);
    chk("pre_rst_head", int'(evt_code), 2);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_ovf", int'(evt_overflow), 0);
    step(2);
    reset = 1'b0;
    t0 = cyc;
    measure(t0, dt, code, nv);
    chk("refire_latency", dt, 9);
    chk("refire_code", code, 5);
    btn = '0; evt_ready = 1'b1;
    step(30);

    // Randomized buttons and backpressure
    pulse_reset();
    for (int b = 0; b < 5; b++) hold[b] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold[b] == 0) begin
          hold[b] = int'($urandom_range(1, 14));
          btn[b] = 1'($urandom_range(0, 1));
        end else begin
          hold[b]--;
        end
      end
      evt_ready = (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      step(1);
    end
    btn = '0; evt_ready = 1'b1;
    step(40);
    chk("rand_drained", int'(evt_valid), 0);

`ifdef BUTTON_AUTO_REPEAT_EN
    // DOWN held for 60 cycles: press plus five repeats
    pulse_reset();
    evt_ready = 1'b1;
    btn[1] = 1'b1;
    nv = 0;
    for (int i = 0; i < 90; i++) begin
      @(posedge clk); #2;
      if (i == 59) btn[1] = 1'b0;
      @(negedge clk);
      if (evt_valid && evt_ready && evt_code == 3'd2) nv++;
    end
    chk("repeat_count", nv, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_source.md
BUTTON_EVENT_SOURCE -- requirements
Module: button_event_source

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the stable-input time required before a debounced level changes (10 ms at 25 MHz).
REQ-002 Parameter REPEAT_DELAY, default 12500000, is the hold time before the first auto-repeat (500 ms).
REQ-003 Parameter REPEAT_PERIOD, default 3750000, is the interval between subsequent auto-repeats (150 ms).
REQ-004 Parameter FIFO_DEPTH, default 4, is the event queue depth, a power of two, at least 2.
REQ-005 Port clk, input, 1 bit: single 25 MHz clock; all state is on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Ports BTNU, BTND, BTNL, BTNR, BTNC, input, 1 bit each: raw asynchronous push-buttons, high when pressed.
REQ-008 Port evt_valid, output, 1 bit: the queue head holds an event.
REQ-009 Port evt_code, output, 3 bits: event code: 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 CENTER; 0 whenever evt_valid is low.
REQ-010 Port evt_ready, input, 1 bit: the consumer accepts the head in any cycle where evt_valid and evt_ready are both high.
REQ-011 Port evt_overflow, output, 1 bit: sticky flag set when an event is dropped because the queue is full.

Function
REQ-012 Each button shall pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Per button, a counter shall reset whenever the synchronized input equals the debounced level; the debounced level shall toggle when the counter reaches DEBOUNCE_CYCLES-1 with the input still differing.
REQ-014 A debounced 0->1 transition shall set that button's pending flag; a release shall generate no event.
REQ-015 The arbiter shall push at most one pending event per cycle, priority CENTER > UP > DOWN > LEFT > RIGHT, and clear only the pushed flag.
REQ-016 Cycle-level latency: a button first high and stable at edge t, with the queue empty and no other flag pending, shall give evt_valid=1 with its code at edge t+DEBOUNCE_CYCLES+4.
REQ-017 If the queue is full when the arbiter selects a flag, the flag shall be cleared, the event discarded, and evt_overflow set; queued events are unaffected.
REQ-018 A push and a pop in the same cycle on a full queue shall both succeed, with no drop.
REQ-019 The queue shall be FIFO-ordered; evt_valid and evt_code shall hold stable until accepted.
REQ-020 Read and write pointers shall wrap modulo FIFO_DEPTH, using one extra bit to distinguish full from empty.
REQ-021 A press arriving while the same button's flag is still pending shall merge into it, so no duplicate is queued.

Reset
REQ-022 While reset is high: synchronizers, debounced levels, counters, pending flags, repeat timers, and pointers shall be 0; evt_valid=0, evt_code=0, evt_overflow=0.
REQ-023 Reset asserted mid-operation shall discard all queued and pending events immediately.
REQ-024 A button held through reset release shall produce a press event after the normal debounce latency.

Configuration
REQ-025 Macro BUTTON_AUTO_REPEAT_EN, when defined, shall add per-direction repeat timers.
REQ-026 With BUTTON_AUTO_REPEAT_EN, a direction button held REPEAT_DELAY cycles after its press shall set its pending flag, then set it again every REPEAT_PERIOD cycles until release; CENTER never repeats.
REQ-027 Without BUTTON_AUTO_REPEAT_EN, no repeat logic shall exist, and one press shall give exactly one event.

Structure
REQ-028 Event code constants (EVT_NONE, EVT_UP, EVT_DOWN, EVT_LEFT, EVT_RIGHT, EVT_CENTER) shall live in the shared chess package, used by the board logic too.
REQ-029 One sub-module, button_debounce (synchronizer, counter, debounced level, rise pulse), shall be instantiated five times; the arbiter, repeat timers, and FIFO stay in the parent.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, FIFO_DEPTH=4)
REQ-030 BTNU high from edge 10, evt_ready=1 -> evt_valid=1, evt_code=1 at edge 18 for one cycle; no further events.
REQ-031 BTNL glitches high for 3 cycles, repeated 5 times -> no event, evt_valid stays 0.
REQ-032 BTNC and BTNR rise on the same cycle, evt_ready=0 -> queue holds 5 then 4, in that order.
REQ-033 Six distinct presses with evt_ready=0 -> 4 events queued, evt_overflow=1, head remains the first event.
REQ-034 BTND held 60 cycles with BUTTON_AUTO_REPEAT_EN, evt_ready=1 -> code 2 events at press, +20, +28, +36, +44, +52 cycles.
REQ-035 Reset pulsed while 3 events are queued -> evt_valid=0, evt_overflow=0 next cycle; a held button re-fires after 8 cycles.
